// File: rtl/seg7_scan_x4.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-coherent shadow digits and dead-time.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_x4 #(
   parameter int BLANK_CYCLES   = 2,
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit ACTIVE_LOW_DIG = 1'b1
) (
   input  logic        clkIn,
   input  logic        resetIn,
   input  logic        tickIn,
   input  logic        loadIn,
   input  logic [15:0] digitsIn,
   input  logic [3:0]  dpIn,
   output logic [6:0]  segOut,
   output logic        dpOut,
   output logic [3:0]  digitSelOut,
   output logic        frameOut
);

   typedef enum logic {BLANK, SHOW} state_t;

   localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES - 1);
   localparam logic [6:0] SEG_OFF    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
   localparam logic       DP_OFF     = ACTIVE_LOW_SEG;
   localparam logic [3:0] DIG_OFF    = ACTIVE_LOW_DIG ? 4'hF : 4'h0;

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic [1:0]  idx, idx_nx;
   logic [15:0] stage_dig, shadow_dig, shadow_dig_nx;
   logic [3:0]  stage_dp, shadow_dp, shadow_dp_nx;
   logic [3:0]  cur_val;
   logic        blank_digit;
   logic [6:0]  seg_nx;
   logic        dp_nx;
   logic [3:0]  sel_nx;
   logic        frame_nx;

   // Active-high segment pattern {g,f,e,d,c,b,a}, full hex.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      idx_nx        = idx;
      shadow_dig_nx = shadow_dig;
      shadow_dp_nx  = shadow_dp;
      frame_nx      = 1'b0;
      case (state)
         SHOW: begin
            if (tickIn) begin
               state_nx = BLANK;
               cnt_nx   = BLANK_INIT;
            end
         end
         default: begin
            if (cnt == 8'd0) begin
               state_nx = SHOW;
               idx_nx   = idx + 2'd1;
               // Entering digit 0 starts a frame: latch the newest staged (or bypassed) digits.
               if (idx == 2'd3) begin
                  frame_nx      = 1'b1;
                  shadow_dig_nx = loadIn ? digitsIn : stage_dig;
                  shadow_dp_nx  = loadIn ? dpIn : stage_dp;
               end
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
      endcase
   end

   // Outputs are computed from next-state values so the registered outputs line up with the state.
   always_comb begin
      cur_val = shadow_dig_nx[{idx_nx, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
      case (idx_nx)
         2'd3:    blank_digit = (shadow_dig_nx[15:12] == 4'h0);
         2'd2:    blank_digit = (shadow_dig_nx[15:8] == 8'h00);
         2'd1:    blank_digit = (shadow_dig_nx[15:4] == 12'h000);
         default: blank_digit = 1'b0;
      endcase
`else
      blank_digit = 1'b0;
`endif
      seg_nx = SEG_OFF;
      dp_nx  = DP_OFF;
      sel_nx = DIG_OFF;
      if (state_nx == SHOW) begin
         seg_nx = blank_digit ? SEG_OFF
                : (ACTIVE_LOW_SEG ? ~hex7(cur_val) : hex7(cur_val));
         dp_nx  = shadow_dp_nx[idx_nx] ^ ACTIVE_LOW_SEG;
         sel_nx = (4'b0001 << idx_nx) ^ DIG_OFF;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the shadow copy is reset because a
   // display must come up blank-clean rather than showing power-up garbage.
   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         state       <= BLANK;
         cnt         <= BLANK_INIT;
         idx         <= 2'd3;
         stage_dig   <= 16'h0000;
         stage_dp    <= 4'h0;
         shadow_dig  <= 16'h0000;
         shadow_dp   <= 4'h0;
         segOut      <= SEG_OFF;
         dpOut       <= DP_OFF;
         digitSelOut <= DIG_OFF;
         frameOut    <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         idx         <= idx_nx;
         shadow_dig  <= shadow_dig_nx;
         shadow_dp   <= shadow_dp_nx;
         segOut      <= seg_nx;
         dpOut       <= dp_nx;
         digitSelOut <= sel_nx;
         frameOut    <= frame_nx;
         if (loadIn) begin
            stage_dig <= digitsIn;
            stage_dp  <= dpIn;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_x4.sv
// Directed self-checking bench for seg7_scan_x4 (BLANK_CYCLES=2, active-low segments and digits).
module tb_seg7_scan_x4;

   logic        clkIn = 1'b0;
   logic        resetIn, tickIn, loadIn;
   logic [15:0] digitsIn;
   logic [3:0]  dpIn;
   logic [6:0]  segOut;
   logic        dpOut;
   logic [3:0]  digitSelOut;
   logic        frameOut;
   logic [12:0] obs;

   int tests = 0;
   int fails = 0;

   localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111, DOFF = 4'b1111;
   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, SA = 7'b0001000, SOFF = 7'b1111111;
`ifdef SEG7_LZB_EN
   localparam logic [6:0] LZ = SOFF;
`else
   localparam logic [6:0] LZ = S0;
`endif
   localparam logic [12:0] ALL_OFF = {DOFF, SOFF, 1'b1, 1'b0};

   seg7_scan_x4 #(.BLANK_CYCLES(2), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_DIG(1'b1)) dut (
      .clkIn(clkIn), .resetIn(resetIn), .tickIn(tickIn), .loadIn(loadIn),
      .digitsIn(digitsIn), .dpIn(dpIn), .segOut(segOut), .dpOut(dpOut),
      .digitSelOut(digitSelOut), .frameOut(frameOut)
   );

   always #5 clkIn = ~clkIn;
   assign obs = {digitSelOut, segOut, dpOut, frameOut};

   // Stimulus only: idle, pulse tick, then count all-off clocks until a digit is selected.
   task automatic advance(input int spacing, output int bl);
      repeat (spacing) @(negedge clkIn);
      tickIn = 1'b1;
      @(negedge clkIn);
      tickIn = 1'b0;
      bl = 0;
      while (digitSelOut === DOFF && bl < 20) begin
         bl++;
         @(negedge clkIn);
      end
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] p);
      @(negedge clkIn);
      digitsIn = d; dpIn = p; loadIn = 1'b1;
      @(negedge clkIn);
      loadIn = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clkIn);
      tests++; if (obs !== ALL_OFF) begin fails++; $display("FAIL reset_hold: got %h want %h", obs, ALL_OFF); end
      resetIn = 1'b1;
      @(negedge clkIn);
      tests++; if (obs !== ALL_OFF) begin fails++; $display("FAIL reset_clk1: got %h want %h", obs, ALL_OFF); end
      @(negedge clkIn);
      tests++; if (obs !== {D0, S0, 2'b11}) begin fails++; $display("FAIL reset_first_digit: got %h want %h", obs, {D0, S0, 2'b11}); end
      @(negedge clkIn);
      tests++; if (obs !== {D0, S0, 2'b10}) begin fails++; $display("FAIL reset_frame_drop: got %h want %h", obs, {D0, S0, 2'b10}); end
   endtask

   task automatic test_scan();
      logic [12:0] expv [8];
      int bl;
      expv = '{{D1, S0, 2'b10}, {D2, S0, 2'b10}, {D3, S0, 2'b10}, {D0, S4, 2'b11},
               {D1, S3, 2'b10}, {D2, S2, 2'b10}, {D3, S1, 2'b10}, {D0, S4, 2'b11}};
      load(16'h1234, 4'h0);
      for (int i = 0; i < 8; i++) begin
         advance(98, bl);
         tests++; if (bl !== 2) begin fails++; $display("FAIL scan%0d_blank: got %0d want 2", i, bl); end
         tests++; if (obs !== expv[i]) begin fails++; $display("FAIL scan%0d_digit: got %h want %h", i, obs, expv[i]); end
      end
   endtask

   task automatic test_midframe_load();
      logic [12:0] expv [5];
      int bl;
      expv = '{{D1, S3, 2'b10}, {D2, S2, 2'b10}, {D3, S1, 2'b10}, {D0, S8, 2'b11}, {D1, S7, 2'b10}};
      for (int i = 0; i < 5; i++) begin
         if (i == 1) load(16'h5678, 4'h0);
         advance(10, bl);
         tests++; if (bl !== 2) begin fails++; $display("FAIL mid%0d_blank: got %0d want 2", i, bl); end
         tests++; if (obs !== expv[i]) begin fails++; $display("FAIL mid%0d_digit: got %h want %h", i, obs, expv[i]); end
      end
   endtask

   task automatic test_tick_held();
      repeat (5) @(negedge clkIn);
      tickIn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clkIn);
         tests++; if (obs !== ALL_OFF) begin fails++; $display("FAIL held_blank%0d: got %h want %h", i, obs, ALL_OFF); end
      end
      @(negedge clkIn);
      tests++; if (obs !== {D2, S6, 2'b10}) begin fails++; $display("FAIL held_next: got %h want %h", obs, {D2, S6, 2'b10}); end
      tickIn = 1'b0;
      repeat (5) @(negedge clkIn);
      tests++; if (obs !== {D2, S6, 2'b10}) begin fails++; $display("FAIL held_single_step: got %h want %h", obs, {D2, S6, 2'b10}); end
   endtask

   task automatic test_lzb();
      logic [12:0] expv [5];
      int bl;
      expv = '{{D3, S5, 2'b10}, {D0, S0, 2'b11}, {D1, SA, 2'b10}, {D2, LZ, 2'b00}, {D3, LZ, 2'b10}};
      load(16'h00A0, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         advance(10, bl);
         tests++; if (bl !== 2) begin fails++; $display("FAIL lzb%0d_blank: got %0d want 2", i, bl); end
         tests++; if (obs !== expv[i]) begin fails++; $display("FAIL lzb%0d_digit: got %h want %h", i, obs, expv[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [12:0] expv [3];
      int bl;
      expv = '{{D0, S0, 2'b11}, {D1, SA, 2'b10}, {D2, LZ, 2'b00}};
      for (int i = 0; i < 3; i++) begin
         advance(10, bl);
         tests++; if (obs !== expv[i]) begin fails++; $display("FAIL rmid%0d_pre: got %h want %h", i, obs, expv[i]); end
      end
      #2 resetIn = 1'b0;
      #1;
      tests++; if (obs !== ALL_OFF) begin fails++; $display("FAIL rmid_async_off: got %h want %h", obs, ALL_OFF); end
      @(negedge clkIn);
      resetIn = 1'b1;
      @(negedge clkIn);
      tests++; if (obs !== ALL_OFF) begin fails++; $display("FAIL rmid_clk1: got %h want %h", obs, ALL_OFF); end
      @(negedge clkIn);
      tests++; if (obs !== {D0, S0, 2'b11}) begin fails++; $display("FAIL rmid_restart: got %h want %h", obs, {D0, S0, 2'b11}); end
      advance(10, bl);
      tests++; if (obs !== {D1, LZ, 2'b10}) begin fails++; $display("FAIL rmid_shadow_d1: got %h want %h", obs, {D1, LZ, 2'b10}); end
      advance(10, bl);
      tests++; if (obs !== {D2, LZ, 2'b10}) begin fails++; $display("FAIL rmid_shadow_d2: got %h want %h", obs, {D2, LZ, 2'b10}); end
   endtask

   initial begin
      resetIn = 1'b1; tickIn = 1'b0; loadIn = 1'b0; digitsIn = 16'h0; dpIn = 4'h0;
      #2 resetIn = 1'b0;
      test_reset();
      test_scan();
      test_midframe_load();
      test_tick_held();
      test_lzb();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
      $fatal(1);
   end

endmodule
